// File: rtl/bus_load.sv
// rtl/bus_load.sv - bus-load side of the 8-bit datapath: register captures, PC advance, RAM write, OUT handshake
// Optional macro BUS_LOAD_OVERRUN_EN builds the sticky out_overrun flag; otherwise it is tied to 0.
module bus_load (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] BUS,
  input  logic       AIn,
  input  logic       BIn,
  input  logic       IIn,
  input  logic       MIn,
  input  logic       JIn,
  input  logic       OIn,
  input  logic       RIn,
  input  logic       CEn,
  input  logic       HLTn,
  output logic [7:0] A,
  output logic [7:0] B,
  output logic [7:0] IR,
  output logic [7:0] MAR,
  output logic [7:0] PC,
  output logic       ram_we,
  output logic [7:0] ram_addr,
  output logic [7:0] ram_wdata,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_overrun
);

  logic load_a, load_b, load_ir, load_mar, load_pc, load_out, inc_pc;

  // Every strobe is qualified by HLTn so a halted machine freezes its state.
  assign load_a   = ~AIn & HLTn;
  assign load_b   = ~BIn & HLTn;
  assign load_ir  = ~IIn & HLTn;
  assign load_mar = ~MIn & HLTn;
  assign load_pc  = ~JIn & HLTn;
  assign load_out = ~OIn & HLTn;
  assign inc_pc   = ~CEn & HLTn;

  assign ram_we    = ~RIn & HLTn;
  assign ram_addr  = MAR;
  assign ram_wdata = BUS;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      A   <= 8'h00;
      B   <= 8'h00;
      IR  <= 8'h00;
      MAR <= 8'h00;
      PC  <= 8'h00;
    end else begin
      if (load_a)   A   <= BUS;
      if (load_b)   B   <= BUS;
      if (load_ir)  IR  <= BUS;
      if (load_mar) MAR <= BUS;
      // A jump load beats a same-cycle increment.
      if (load_pc)     PC <= BUS;
      else if (inc_pc) PC <= PC + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= 8'h00;
      out_valid <= 1'b0;
    end else if (load_out) begin
      out_data  <= BUS;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef BUS_LOAD_OVERRUN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      out_overrun <= 1'b0;
    else if (load_out && out_valid && !out_ready)
      out_overrun <= 1'b1;
  end
`else
  assign out_overrun = 1'b0;
`endif

endmodule

// File: tb/tb_bus_load.sv
// tb/tb_bus_load.sv - self-checking bench for bus_load: directed vector table, async reset sequence, random run vs model
module tb_bus_load;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] BUS;
  logic       AIn, BIn, IIn, MIn, JIn, OIn, RIn, CEn, HLTn, out_ready;
  logic [7:0] A, B, IR, MAR, PC, ram_addr, ram_wdata, out_data;
  logic       ram_we, out_valid, out_overrun;

  always #5 clk = ~clk;

  bus_load dut (
    .clk(clk), .rst_n(rst_n), .BUS(BUS),
    .AIn(AIn), .BIn(BIn), .IIn(IIn), .MIn(MIn), .JIn(JIn), .OIn(OIn),
    .RIn(RIn), .CEn(CEn), .HLTn(HLTn),
    .A(A), .B(B), .IR(IR), .MAR(MAR), .PC(PC),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_overrun(out_overrun)
  );

`ifdef BUS_LOAD_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Strobe order: {AIn,BIn,IIn,MIn,JIn,OIn,RIn,CEn,HLTn,out_ready}
  typedef struct {
    logic [7:0] bus;
    logic [9:0] n;
    logic [7:0] ea, eb, eir, emar, epc, eout;
    logic       evalid, eovr, ewe;
    logic [7:0] eaddr;
  } vec_t;

  vec_t tbl[13];

  task automatic drive(input logic [7:0] bus, input logic [9:0] n);
    BUS = bus;
    {AIn, BIn, IIn, MIn, JIn, OIn, RIn, CEn, HLTn, out_ready} = n;
  endtask

  task automatic chk_all(input string tag, input logic [7:0] ea, eb, eir, emar, epc, eout,
                         input logic ev, eo);
    chk({tag, " A"}, A, ea);
    chk({tag, " B"}, B, eb);
    chk({tag, " IR"}, IR, eir);
    chk({tag, " MAR"}, MAR, emar);
    chk({tag, " PC"}, PC, epc);
    chk({tag, " out_data"}, out_data, eout);
    chk({tag, " out_valid"}, out_valid, ev);
    chk({tag, " out_overrun"}, out_overrun, eo);
  endtask

  // Reference state for the random run
  logic [7:0] m_a, m_b, m_ir, m_mar, m_pc, m_out;
  logic       m_valid, m_ovr;

  initial begin
    tbl[0]  = '{8'h3C, 10'b0011111110, 8'h3C, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0,   1'b0, 8'h00};
    tbl[1]  = '{8'hFF, 10'b1111011110, 8'h3C, 8'h3C, 8'h00, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b0,   1'b0, 8'h00};
    tbl[2]  = '{8'h00, 10'b1111111010, 8'h3C, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0,   1'b0, 8'h00};
    tbl[3]  = '{8'h42, 10'b1111011010, 8'h3C, 8'h3C, 8'h00, 8'h00, 8'h42, 8'h00, 1'b0, 1'b0,   1'b0, 8'h00};
    tbl[4]  = '{8'h05, 10'b1110111110, 8'h3C, 8'h3C, 8'h00, 8'h05, 8'h42, 8'h00, 1'b0, 1'b0,   1'b0, 8'h00};
    tbl[5]  = '{8'h99, 10'b1110110110, 8'h3C, 8'h3C, 8'h00, 8'h99, 8'h42, 8'h00, 1'b0, 1'b0,   1'b1, 8'h05};
    tbl[6]  = '{8'h11, 10'b1111101110, 8'h3C, 8'h3C, 8'h00, 8'h99, 8'h42, 8'h11, 1'b1, 1'b0,   1'b0, 8'h99};
    tbl[7]  = '{8'h22, 10'b1111101111, 8'h3C, 8'h3C, 8'h00, 8'h99, 8'h42, 8'h22, 1'b1, 1'b0,   1'b0, 8'h99};
    tbl[8]  = '{8'h55, 10'b0000000001, 8'h3C, 8'h3C, 8'h00, 8'h99, 8'h42, 8'h22, 1'b0, 1'b0,   1'b0, 8'h99};
    tbl[9]  = '{8'h77, 10'b1101111110, 8'h3C, 8'h3C, 8'h77, 8'h99, 8'h42, 8'h22, 1'b0, 1'b0,   1'b0, 8'h99};
    tbl[10] = '{8'h44, 10'b1111101110, 8'h3C, 8'h3C, 8'h77, 8'h99, 8'h42, 8'h44, 1'b1, 1'b0,   1'b0, 8'h99};
    tbl[11] = '{8'h33, 10'b1111101110, 8'h3C, 8'h3C, 8'h77, 8'h99, 8'h42, 8'h33, 1'b1, OVR_EN, 1'b0, 8'h99};
    tbl[12] = '{8'h00, 10'b1111111111, 8'h3C, 8'h3C, 8'h77, 8'h99, 8'h42, 8'h33, 1'b0, OVR_EN, 1'b0, 8'h99};

    rst_n = 1'b0;
    drive(8'h00, 10'b1111111110);
    #2;
    chk_all("reset", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(tbl[i].bus, tbl[i].n);
      #1;
      chk($sformatf("vec%0d ram_we", i), ram_we, tbl[i].ewe);
      chk($sformatf("vec%0d ram_addr", i), ram_addr, tbl[i].eaddr);
      chk($sformatf("vec%0d ram_wdata", i), ram_wdata, tbl[i].bus);
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), tbl[i].ea, tbl[i].eb, tbl[i].eir, tbl[i].emar,
              tbl[i].epc, tbl[i].eout, tbl[i].evalid, tbl[i].eovr);
    end

    // Async reset between edges with a pending OUT value
    @(negedge clk);
    drive(8'h7E, 10'b0111101110);
    @(posedge clk);
    #1;
    chk("pre-rst A", A, 8'h7E);
    chk("pre-rst out_valid", out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async rst", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_all("rst held", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #3;
    chk_all("rst released", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("first edge A", A, 8'h7E);
    chk("first edge out_valid", out_valid, 1'b1);

    // Fresh reset, then a random run against the reference model
    @(negedge clk);
    drive(8'h00, 10'b1111111110);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    {m_a, m_b, m_ir, m_mar, m_pc, m_out} = '0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;

    for (int c = 0; c < 1500; c++) begin
      logic [7:0] bus;
      logic a_n, b_n, i_n, m_n, j_n, o_n, r_n, ce_n, h_n, rdy;
      @(negedge clk);
      bus  = 8'($urandom);
      a_n  = ($urandom_range(0, 3) != 0);
      b_n  = ($urandom_range(0, 3) != 0);
      i_n  = ($urandom_range(0, 3) != 0);
      m_n  = ($urandom_range(0, 3) != 0);
      j_n  = ($urandom_range(0, 3) != 0);
      o_n  = ($urandom_range(0, 2) != 0);
      r_n  = ($urandom_range(0, 2) != 0);
      ce_n = ($urandom_range(0, 1) != 0);
      h_n  = ($urandom_range(0, 5) != 0);
      rdy  = ($urandom_range(0, 2) == 0);
      drive(bus, {a_n, b_n, i_n, m_n, j_n, o_n, r_n, ce_n, h_n, rdy});
      #1;
      chk("rnd ram_we", ram_we, (!r_n && h_n));
      chk("rnd ram_addr", ram_addr, m_mar);
      chk("rnd ram_wdata", ram_wdata, bus);

      if (h_n) begin
        if (!a_n) m_a = bus;
        if (!b_n) m_b = bus;
        if (!i_n) m_ir = bus;
        if (!m_n) m_mar = bus;
        if (!j_n) m_pc = bus;
        else if (!ce_n) m_pc = 8'((int'(m_pc) + 1) % 256);
      end
      if (h_n && !o_n) begin
        if (m_valid && !rdy && OVR_EN) m_ovr = 1'b1;
        m_out   = bus;
        m_valid = 1'b1;
      end else if (m_valid && rdy) begin
        m_valid = 1'b0;
      end

      @(posedge clk);
      #1;
      chk_all("rnd", m_a, m_b, m_ir, m_mar, m_pc, m_out, m_valid, m_ovr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
